// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED sequencer: pattern modes, FSM states and the
// value each pattern starts from.
package led_sequencer_pkg;

  localparam int LED_W = 10;

  typedef enum logic [1:0] {
    MODE_WALK   = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  localparam logic [LED_W-1:0] INIT_WALK   = 10'h001;
  localparam logic [LED_W-1:0] INIT_BOUNCE = 10'h001;
  localparam logic [LED_W-1:0] INIT_COUNT  = 10'h000;
  localparam logic [LED_W-1:0] INIT_BLINK  = 10'h3FF;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic [LED_W-1:0] mode_init(input mode_e m);
    case (m)
      MODE_WALK:   mode_init = INIT_WALK;
      MODE_BOUNCE: mode_init = INIT_BOUNCE;
      MODE_COUNT:  mode_init = INIT_COUNT;
      MODE_BLINK:  mode_init = INIT_BLINK;
      default:     mode_init = INIT_WALK;
    endcase
  endfunction

endpackage

// File: rtl/led_sequencer_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debouncer and a one-cycle
// pulse on each accepted press (high-to-low). Releases never pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          db_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;
  logic          btn_s;

  assign btn_s = sync_q[1];

  // Until the input has been seen stably released, nothing counts as a press:
  // a button held through reset must be let go before it can start anything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      db_q    <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      press_q <= 1'b0;
      if (!armed_q) begin
        if (btn_s) begin
          if (cnt_q == CNT_LAST) begin
            armed_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end else if (btn_s != db_q) begin
        if (cnt_q == CNT_LAST) begin
          db_q    <= btn_s;
          cnt_q   <= '0;
          press_q <= ~btn_s;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_sequencer.sv
// Ten-LED pattern sequencer: run/pause and clear buttons drive an IDLE/RUN/PAUSE
// FSM; a speed-scaled prescaler steps one of four patterns.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int BASE_DIV        = 2_500_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run_n,
  input  logic             btn_clr_n,
  input  logic [1:0]       mode,
  input  logic [2:0]       speed,
  output logic [LED_W-1:0] led,
  output logic             running,
  output logic             paused
);

  // Wide enough for the slowest speed; a speed drop below the current count
  // lets the counter run on to its natural wrap.
  localparam int PW = $clog2(BASE_DIV * 8);

  logic             run_pulse;
  logic             clr_pulse;

  state_e           state_q;
  logic [LED_W-1:0] led_q;
  logic             dir_q;
  mode_e            mode_q;
  logic [PW-1:0]    presc_q;
  logic             running_q;
  logic             paused_q;

  mode_e            mode_in;
  logic [31:0]      period_m1;
  logic             step_tick;
  logic [LED_W-1:0] step_led_d;
  logic             step_dir_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_run_n),
    .press_o (run_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_clr_n),
    .press_o (clr_pulse)
  );

  assign mode_in   = mode_e'(mode);
  assign period_m1 = 32'(BASE_DIV) * ({29'd0, speed} + 32'd1) - 32'd1;
  assign step_tick = ({{(32-PW){1'b0}}, presc_q} == period_m1);

  always_comb begin
    step_led_d = led_q;
    step_dir_d = dir_q;
    case (mode_q)
      MODE_WALK:   step_led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
      MODE_BOUNCE: begin
        if (dir_q == DIR_UP) begin
          if (led_q[LED_W-1]) begin
            step_led_d = led_q >> 1;
            step_dir_d = DIR_DOWN;
          end else begin
            step_led_d = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            step_led_d = led_q << 1;
            step_dir_d = DIR_UP;
          end else begin
            step_led_d = led_q >> 1;
          end
        end
      end
      MODE_COUNT:  step_led_d = led_q + 10'd1;
      MODE_BLINK:  step_led_d = ~led_q;
      default:     step_led_d = led_q;
    endcase
  end

  // Clear outranks everything, including a run press in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      led_q     <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= MODE_WALK;
      presc_q   <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else if (clr_pulse) begin
      state_q   <= ST_IDLE;
      led_q     <= '0;
      dir_q     <= DIR_UP;
      presc_q   <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_pulse) begin
            state_q   <= ST_RUN;
            led_q     <= mode_init(mode_in);
            mode_q    <= mode_in;
            dir_q     <= DIR_UP;
            presc_q   <= '0;
            running_q <= 1'b1;
            paused_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (run_pulse) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
            paused_q  <= 1'b1;
          end else if (step_tick) begin
            presc_q <= '0;
            mode_q  <= mode_in;
            if (mode_in != mode_q) begin
              led_q <= mode_init(mode_in);
              dir_q <= DIR_UP;
            end else begin
              led_q <= step_led_d;
              dir_q <= step_dir_d;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (run_pulse) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            paused_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          paused_q  <= 1'b0;
        end
      endcase
    end
  end

  assign led     = led_q;
  assign running = running_q;
  assign paused  = paused_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with BASE_DIV=4 and DEBOUNCE_CYCLES=8.
module tb_led_sequencer;

  localparam int BASE_DIV = 4;
  localparam int DEB      = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_run_n = 1'b1;
  logic       btn_clr_n = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [2:0] speed = 3'd0;
  logic [9:0] led;
  logic       running;
  logic       paused;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];

  led_sequencer #(.BASE_DIV(BASE_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_run_n (btn_run_n),
    .btn_clr_n (btn_clr_n),
    .mode      (mode),
    .speed     (speed),
    .led       (led),
    .running   (running),
    .paused    (paused)
  );

  always #5 clk = ~clk;

  // Press run and wait (bounded) for the state outputs to change, then release.
  task automatic press_run();
    logic [1:0] prev;
    bit seen;
    prev = {running, paused};
    seen = 1'b0;
    btn_run_n = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ({running, paused} !== prev) seen = 1'b1;
    end
    btn_run_n = 1'b1;
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL run_press: state %b unchanged after 40 cycles, required a change", prev);
    end
  endtask

  task automatic press_clr();
    btn_clr_n = 1'b0;
    repeat (14) @(negedge clk);
    btn_clr_n = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (led !== 10'h000) begin n_err++; $display("FAIL reset_led: got %h required 000", led); end
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b required 0", running); end
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL reset_paused: got %b required 0", paused); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if ({running, paused, led} !== 12'h000) begin n_err++; $display("FAIL idle_after_reset: got %b/%b/%h required 0/0/000", running, paused, led); end
  endtask

  task automatic test_walk();
    logic [9:0] tbl [10] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
                             10'h040, 10'h080, 10'h100, 10'h200, 10'h001};
    logic [9:0] e;
    mode = 2'b00; speed = 3'd0;
    press_run();
    n_cmp++; if (led !== 10'h001) begin n_err++; $display("FAIL walk_entry: got %h required 001", led); end
    for (int i = 0; i < 10; i++) exp_q.push_back(tbl[i]);
    while (exp_q.size() > 0) begin
      repeat (4) @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (led !== e) begin n_err++; $display("FAIL walk_step: got %h required %h", led, e); end
    end
    press_clr();
    n_cmp++; if ({running, paused, led} !== 12'h000) begin n_err++; $display("FAIL walk_clear: got %b/%b/%h required 0/0/000", running, paused, led); end
  endtask

  task automatic test_bounce();
    logic [9:0] tbl [19] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040,
                             10'h080, 10'h100, 10'h200, 10'h100, 10'h080, 10'h040,
                             10'h020, 10'h010, 10'h008, 10'h004, 10'h002, 10'h001,
                             10'h002};
    logic [9:0] e;
    mode = 2'b01; speed = 3'd1;
    press_run();
    n_cmp++; if (led !== 10'h001) begin n_err++; $display("FAIL bounce_entry: got %h required 001", led); end
    for (int i = 0; i < 19; i++) exp_q.push_back(tbl[i]);
    while (exp_q.size() > 0) begin
      repeat (7) @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (led === e) begin n_err++; $display("FAIL bounce_early: got %h one cycle before the step, required the old value", led); end
      @(negedge clk);
      n_cmp++; if (led !== e) begin n_err++; $display("FAIL bounce_step: got %h required %h", led, e); end
    end
    press_clr();
  endtask

  task automatic test_count_pause();
    mode = 2'b10; speed = 3'd0;
    press_run();
    n_cmp++; if (led !== 10'h000) begin n_err++; $display("FAIL count_entry: got %h required 000", led); end
    repeat (1023 * 4) @(negedge clk);
    n_cmp++; if (led !== 10'h3FF) begin n_err++; $display("FAIL count_1023: got %h required 3FF", led); end
    repeat (4) @(negedge clk);
    n_cmp++; if (led !== 10'h000) begin n_err++; $display("FAIL count_wrap: got %h required 000", led); end
    // Pause lands 11 edges after the press: two more ticks, prescaler held at 2.
    press_run();
    n_cmp++; if ({running, paused} !== 2'b01) begin n_err++; $display("FAIL pause_state: got %b%b required 01", running, paused); end
    n_cmp++; if (led !== 10'h002) begin n_err++; $display("FAIL pause_led: got %h required 002", led); end
    mode = 2'b11;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++; if (led !== 10'h002) begin n_err++; $display("FAIL pause_frozen: cycle %0d got %h required 002", i, led); end
    end
    mode = 2'b10;
    press_run();
    n_cmp++; if ({running, paused} !== 2'b10) begin n_err++; $display("FAIL resume_state: got %b%b required 10", running, paused); end
    n_cmp++; if (led !== 10'h002) begin n_err++; $display("FAIL resume_no_reload: got %h required 002", led); end
    repeat (2) @(negedge clk);
    n_cmp++; if (led !== 10'h003) begin n_err++; $display("FAIL resume_prescaler: got %h required 003", led); end
    repeat (4) @(negedge clk);
    n_cmp++; if (led !== 10'h004) begin n_err++; $display("FAIL resume_step: got %h required 004", led); end
    press_clr();
    n_cmp++; if ({running, paused, led} !== 12'h000) begin n_err++; $display("FAIL count_clear: got %b/%b/%h required 0/0/000", running, paused, led); end
  endtask

  task automatic test_button_bounce();
    logic [1:0] prev;
    int changes;
    changes = 0;
    mode = 2'b00; speed = 3'd0;
    prev = {running, paused};
    for (int i = 0; i < 90; i++) begin
      if (i < 20) btn_run_n = ((i / 3) % 2 == 1);
      else if (i < 60) btn_run_n = 1'b0;
      else btn_run_n = 1'b1;
      @(negedge clk);
      if ({running, paused} !== prev) begin
        changes++;
        prev = {running, paused};
      end
    end
    n_cmp++; if (changes !== 1) begin n_err++; $display("FAIL bounce_changes: got %0d state changes required 1", changes); end
    n_cmp++; if ({running, paused} !== 2'b10) begin n_err++; $display("FAIL bounce_state: got %b%b required 10", running, paused); end
    press_clr();
  endtask

  task automatic test_simultaneous();
    mode = 2'b00; speed = 3'd0;
    press_run();
    repeat (20) @(negedge clk);
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL simul_pre: running %b required 1", running); end
    btn_run_n = 1'b0;
    btn_clr_n = 1'b0;
    repeat (14) @(negedge clk);
    btn_run_n = 1'b1;
    btn_clr_n = 1'b1;
    repeat (14) @(negedge clk);
    n_cmp++; if ({running, paused} !== 2'b00) begin n_err++; $display("FAIL simul_state: got %b%b required 00", running, paused); end
    n_cmp++; if (led !== 10'h000) begin n_err++; $display("FAIL simul_led: got %h required 000", led); end
  endtask

  task automatic test_mode_change();
    mode = 2'b00; speed = 3'd0;
    press_run();
    n_cmp++; if (led !== 10'h001) begin n_err++; $display("FAIL modechg_entry: got %h required 001", led); end
    mode = 2'b11;
    repeat (4) @(negedge clk);
    n_cmp++; if (led !== 10'h3FF) begin n_err++; $display("FAIL modechg_reload: got %h required 3FF", led); end
    repeat (4) @(negedge clk);
    n_cmp++; if (led !== 10'h000) begin n_err++; $display("FAIL blink_off: got %h required 000", led); end
    repeat (4) @(negedge clk);
    n_cmp++; if (led !== 10'h3FF) begin n_err++; $display("FAIL blink_on: got %h required 3FF", led); end
    press_clr();
  endtask

  task automatic test_reset_mid();
    logic [1:0] prev;
    int changes;
    changes = 0;
    mode = 2'b10; speed = 3'd0;
    press_run();
    repeat (10) @(negedge clk);
    n_cmp++; if (led !== 10'h002) begin n_err++; $display("FAIL rstmid_pre: got %h required 002", led); end
    btn_run_n = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (led !== 10'h000) begin n_err++; $display("FAIL rstmid_led: got %h required 000 before any edge", led); end
    n_cmp++; if ({running, paused} !== 2'b00) begin n_err++; $display("FAIL rstmid_state: got %b%b required 00", running, paused); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prev = {running, paused};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ({running, paused} !== prev) begin
        changes++;
        prev = {running, paused};
      end
    end
    n_cmp++; if (changes !== 0 || running !== 1'b0) begin n_err++; $display("FAIL held_btn_release: %0d changes running %b required 0 and 0", changes, running); end
    btn_run_n = 1'b1;
    repeat (20) @(negedge clk);
    press_run();
    n_cmp++; if ({running, led} !== 11'h400) begin n_err++; $display("FAIL fresh_press: got %b/%h required 1/000", running, led); end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_bounce();
    test_count_pause();
    test_button_bounce();
    test_simultaneous();
    test_mode_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
